// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing a two-stage 2:1 mux chain between X, Y and Z.
// The selected word is registered and offered downstream on valid/ready.
module rr_mux_arbiter #(
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic [W-1:0] Z,
  input  logic         VX,
  input  logic         VY,
  input  logic         VZ,
  output logic         AX,
  output logic         AY,
  output logic         AZ,
  output logic         S1,
  output logic         S2,
  output logic [1:0]   GNT,
  output logic [W-1:0] O,
  output logic         O_VALID,
  input  logic         O_READY
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic         w_load;

  logic [1:0]   r_last;
  logic [2:0]   r_acc;
  logic         r_s1;
  logic         r_s2;
  logic [1:0]   r_gnt;
  logic [W-1:0] r_o;

  logic [2:0]   w_elig;
  logic         w_hit;
  logic [1:0]   w_win;
  logic         w_s1;
  logic         w_s2;
  logic [W-1:0] w_m1;
  logic [W-1:0] w_m2;

  // A requester whose accept is high is retiring that word this cycle.
  assign w_elig = {VZ & ~r_acc[2],
                   VY & ~r_acc[1],
                   VX & ~r_acc[0]};
  assign w_hit  = |w_elig;

  always_comb begin
    w_win = 2'd0;
    unique case (r_last)
      2'd0: begin
        if (w_elig[1])      w_win = 2'd1;
        else if (w_elig[2]) w_win = 2'd2;
        else                w_win = 2'd0;
      end
      2'd1: begin
        if (w_elig[2])      w_win = 2'd2;
        else if (w_elig[0]) w_win = 2'd0;
        else                w_win = 2'd1;
      end
      default: begin
        if (w_elig[0])      w_win = 2'd0;
        else if (w_elig[1]) w_win = 2'd1;
        else                w_win = 2'd2;
      end
    endcase
  end

  assign w_s1 = (w_win == 2'd1);
  assign w_s2 = (w_win == 2'd2);
  assign w_m1 = w_s1 ? Y : X;
  assign w_m2 = w_s2 ? Z : w_m1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= EMPTY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_hit) begin
          w_next = FULL;
          w_load = 1'b1;
        end
      end
      FULL: begin
        if (O_READY) begin
          if (w_hit) w_load = 1'b1;
          else       w_next = EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last <= 2'd2;
      r_acc  <= 3'b000;
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_gnt  <= 2'd0;
      r_o    <= '0;
    end else begin
      r_acc <= 3'b000;
      if (w_load) begin
        r_o    <= w_m2;
        r_s1   <= w_s1;
        r_s2   <= w_s2;
        r_gnt  <= w_win;
        r_last <= w_win;
        r_acc  <= {w_s2, w_s1, ~w_s1 & ~w_s2};
      end
    end
  end

  assign AX      = r_acc[0];
  assign AY      = r_acc[1];
  assign AZ      = r_acc[2];
  assign S1      = r_s1;
  assign S2      = r_s2;
  assign GNT     = r_gnt;
  assign O       = r_o;
  assign O_VALID = (r_state == FULL);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: scenario tasks plus a scoreboard
// fed by an arbitration model and drained on each output handshake.
module tb_rr_mux_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] X, Y, Z;
  logic       VX, VY, VZ;
  logic       AX, AY, AZ;
  logic       S1, S2;
  logic [1:0] GNT;
  logic [1:0] O;
  logic       O_VALID;
  logic       O_READY;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] o;
    logic [1:0] g;
  } exp_t;
  exp_t q[$];

  rr_mux_arbiter #(.W(2)) dut (
    .CLK(CLK), .RST(RST),
    .X(X), .Y(Y), .Z(Z),
    .VX(VX), .VY(VY), .VZ(VZ),
    .AX(AX), .AY(AY), .AZ(AZ),
    .S1(S1), .S2(S2), .GNT(GNT),
    .O(O), .O_VALID(O_VALID),
    .O_READY(O_READY)
  );

  always #5 CLK = ~CLK;

  // Reference arbitration model: predicts every capture.
  bit         m_valid;
  int         m_last;
  bit [2:0]   m_a;
  bit [2:0]   m_el;
  int         m_w;
  logic [1:0] m_wd;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_valid = 0;
      m_last  = 2;
      m_a     = 0;
      q.delete();
    end else begin
      m_el = {VZ && !m_a[2], VY && !m_a[1], VX && !m_a[0]};
      m_w  = -1;
      if (!m_valid || O_READY)
        for (int k = 1; k <= 3; k++)
          if (m_w < 0 && m_el[(m_last + k) % 3])
            m_w = (m_last + k) % 3;
      m_a = 0;
      if (m_w >= 0) begin
        m_wd = (m_w == 0) ? X : (m_w == 1) ? Y : Z;
        q.push_back('{m_wd, 2'(m_w)});
        m_last  = m_w;
        m_valid = 1;
        m_a[m_w] = 1;
      end else if (m_valid && O_READY) begin
        m_valid = 0;
      end
    end
  end

  exp_t e;
  always @(negedge CLK) begin
    if (!RST && O_VALID === 1'b1 && O_READY) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL sb_empty got O=%0d GNT=%0d exp=none", O, GNT);
      end else begin
        e = q.pop_front();
        if (O !== e.o || GNT !== e.g) begin
          failures++;
          $display("FAIL sb_word got O=%0d GNT=%0d exp O=%0d GNT=%0d",
                   O, GNT, e.o, e.g);
        end
      end
    end
  end

  task automatic idle_inputs();
    VX = 0; VY = 0; VZ = 0;
    X = 0; Y = 0; Z = 0;
    O_READY = 0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1;
    idle_inputs();
    #2;
    RST = 0;
  endtask

  task automatic test_reset();
    @(posedge CLK); #1;
    RST = 1;
    idle_inputs();
    #1;
    checks++;
    if (O !== 2'd0 || O_VALID !== 1'b0 || GNT !== 2'd0) begin
      failures++;
      $display("FAIL reset_out got O=%0d V=%0d G=%0d exp 0 0 0",
               O, O_VALID, GNT);
    end
    checks++;
    if ({S1, S2, AX, AY, AZ} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=00000", {S1, S2, AX, AY, AZ});
    end
    RST = 0;
  endtask

  task automatic test_single_x();
    do_reset();
    VX = 1; X = 2'b01; O_READY = 1;
    @(posedge CLK); #1;
    checks++;
    if (O !== 2'b01 || GNT !== 2'd0 || O_VALID !== 1'b1) begin
      failures++;
      $display("FAIL single_x got O=%0d G=%0d V=%0d exp 1 0 1",
               O, GNT, O_VALID);
    end
    checks++;
    if ({S1, S2, AX, AY, AZ} !== 5'b00100) begin
      failures++;
      $display("FAIL single_x_ctl got=%b exp=00100",
               {S1, S2, AX, AY, AZ});
    end
    VX = 0;
    @(posedge CLK); #1;
  endtask

  task automatic test_round_robin();
    logic [1:0] ev;
    logic [2:0] ea;
    do_reset();
    X = 1; Y = 2; Z = 3;
    VX = 1; VY = 1; VZ = 1;
    O_READY = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      ev = 2'((i % 3) + 1);
      ea = 3'(1 << (i % 3));
      checks++;
      if (O !== ev || O_VALID !== 1'b1) begin
        failures++;
        $display("FAIL rr_word[%0d] got=%0d exp=%0d", i, O, ev);
      end
      checks++;
      if ({AZ, AY, AX} !== ea) begin
        failures++;
        $display("FAIL rr_acc[%0d] got=%b exp=%b", i, {AZ, AY, AX}, ea);
      end
    end
    VX = 0; VY = 0; VZ = 0;
    @(posedge CLK); #1;
  endtask

  task automatic test_only_y();
    bit ev;
    do_reset();
    VY = 1; Y = 2'b10; O_READY = 1;
    for (int i = 0; i < 7; i++) begin
      @(posedge CLK); #1;
      ev = (i % 2 == 0);
      checks++;
      if (AY !== ev || O_VALID !== ev) begin
        failures++;
        $display("FAIL only_y[%0d] got AY=%0d V=%0d exp=%0d",
                 i, AY, O_VALID, ev);
      end
      if (ev) begin
        checks++;
        if (O !== 2'b10 || S1 !== 1'b1 || S2 !== 1'b0) begin
          failures++;
          $display("FAIL only_y_sel[%0d] got O=%0d S1=%0d S2=%0d exp 2 1 0",
                   i, O, S1, S2);
        end
      end
    end
    VY = 0;
    @(posedge CLK); #1;
  endtask

  task automatic test_backpressure();
    do_reset();
    VZ = 1; Z = 2'b11; O_READY = 0;
    @(posedge CLK); #1;
    checks++;
    if (O !== 2'b11 || GNT !== 2'd2 || AZ !== 1'b1 || S2 !== 1'b1) begin
      failures++;
      $display("FAIL bp_cap got O=%0d G=%0d AZ=%0d S2=%0d exp 3 2 1 1",
               O, GNT, AZ, S2);
    end
    VZ = 0; VX = 1; X = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (O !== 2'b11 || GNT !== 2'd2 || AX !== 1'b0 || O_VALID !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d] got O=%0d G=%0d AX=%0d V=%0d exp 3 2 0 1",
                 i, O, GNT, AX, O_VALID);
      end
    end
    O_READY = 1;
    @(posedge CLK); #1;
    checks++;
    if (O !== 2'b01 || AX !== 1'b1 || GNT !== 2'd0) begin
      failures++;
      $display("FAIL bp_release got O=%0d AX=%0d G=%0d exp 1 1 0",
               O, AX, GNT);
    end
    VX = 0;
    @(posedge CLK); #1;
  endtask

  task automatic test_drain();
    do_reset();
    VY = 1; Y = 2'b10; O_READY = 1;
    @(posedge CLK); #1;
    VY = 0;
    @(posedge CLK); #1;
    checks++;
    if (O_VALID !== 1'b0 || O !== 2'b10 || GNT !== 2'd1) begin
      failures++;
      $display("FAIL drain got V=%0d O=%0d G=%0d exp 0 2 1",
               O_VALID, O, GNT);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    VY = 1; Y = 2'b10; O_READY = 0;
    @(posedge CLK); #1;
    checks++;
    if (O_VALID !== 1'b1 || AY !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre got V=%0d AY=%0d exp 1 1", O_VALID, AY);
    end
    #2;
    RST = 1;
    #1;
    checks++;
    if (O_VALID !== 1'b0 || AY !== 1'b0 || O !== 2'd0) begin
      failures++;
      $display("FAIL mid_rst got V=%0d AY=%0d O=%0d exp 0 0 0",
               O_VALID, AY, O);
    end
    VX = 1; X = 2'b01; VY = 1; O_READY = 1;
    RST = 0;
    @(posedge CLK); #1;
    checks++;
    if (O !== 2'b01 || GNT !== 2'd0 || AX !== 1'b1) begin
      failures++;
      $display("FAIL mid_first got O=%0d G=%0d AX=%0d exp 1 0 1",
               O, GNT, AX);
    end
    VX = 0;
    @(posedge CLK); #1;
    checks++;
    if (O !== 2'b10 || GNT !== 2'd1 || AY !== 1'b1) begin
      failures++;
      $display("FAIL mid_second got O=%0d G=%0d AY=%0d exp 2 1 1",
               O, GNT, AY);
    end
    VY = 0;
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1;
    idle_inputs();
    test_reset();
    test_single_x();
    test_round_robin();
    test_only_y();
    test_backpressure();
    test_drain();
    test_reset_midop();
    idle_inputs();
    O_READY = 1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
